oflow_registration_ctrl_pipe: RTL
=================================

// Module: oflow_registration_ctrl_pipe
// PURPOSE
//  Parametrised, pipelined registration controller for the oflow core. Sequences num_of_sets PE sets
//  through the score-calc stage, then the score-board stage. Calc of set k+1 overlaps board of set k.
//  On the first frame (frame_num==0) it bypasses score calc and issues new IDs per set.
//  Adds abort, done and empty-error reporting.
// PARAMETERS
//  PE_NUM   24  PEs per set; ID stride per set
//  PE_LEN    5  width of num_of_pe
//  SET_LEN   3  width of set counters / num_of_sets
//  ID_LEN   12  width of id_first_frame
//  FRAME_W  16  width of frame_num
// PORTS
//  clk               in   1        clock
//  reset_N           in   1        async active-low reset
//  start_registration in  1        1-cycle start request
//  abort             in   1        sync abort of current registration
//  frame_num         in   FRAME_W  current frame; 0 = first frame
//  num_of_sets       in   SET_LEN  sets to process this frame
//  num_of_pe         in   PE_LEN   PE index within set, for ID generation
//  done_score_calc   in   1        score calc finished current set
//  start_score_calc  out  1        1-cycle pulse: start calc of calc_set
//  calc_set          out  SET_LEN  set index in calc stage
//  done_score_board  in   1        score board finished current set
//  start_score_board out  1        1-cycle pulse: start board of row_sel_by_set
//  row_sel_by_set    out  SET_LEN  set index in board stage (registered)
//  id_first_frame    out  ID_LEN   new ID for first-frame board set
//  busy              out  1        registration in progress
//  done_registration out  1        1-cycle pulse: all sets registered
//  err_empty         out  1        1-cycle pulse: start with num_of_sets==0
// BEHAVIOUR
//  Clocking and reset:
//  - One clock, clk. reset_N is asynchronous and active-low.
//  - On reset, all outputs, counters and state go to 0, and both sub-FSMs go to IDLE.
//  Start:
//  - Start is accepted only when busy==0; it is ignored while busy.
//  - On accept, frame_num and num_of_sets are latched. first_frame = (frame_num==0).
//  - num_of_sets==0: err_empty pulses next cycle; no other output changes; stays idle.
//  - Otherwise busy=1 from the next cycle.
//  Calc sub-FSM (IDLE -> START -> WAIT -> HOLD):
//  - START drives start_score_calc=1 for exactly 1 cycle with calc_set valid.
//  - WAIT is left on done_score_calc.
//    - If the board stage is free (B_IDLE, or done_score_board in the same cycle), handoff.
//    - Else go to HOLD until the board is free.
//  - Handoff: row_sel_by_set <= calc_set.
//    - If sets remain: calc_set+1 and START. The next cycle has both start pulses asserted together.
//    - Else the calc stage goes to IDLE.
//  Board sub-FSM (IDLE -> START -> WAIT):
//  - START drives start_score_board=1 for 1 cycle. WAIT is left on done_score_board.
//  - A handoff in the same cycle as done_score_board restarts START next cycle (no bubble).
//  First frame:
//  - Calc stage is never started; the board stage sequences sets 0..num_of_sets-1 directly.
//  - id_first_frame = row_sel_by_set*PE_NUM + num_of_pe + 1, truncated to ID_LEN.
//  - id_first_frame is combinational from registered values and is 0 when not first_frame.
//  Completion:
//  - done_score_board for set num_of_sets-1 -> done_registration pulses next cycle.
//  - busy falls in that same cycle.
//  - row_sel_by_set and calc_set hold their last values until the next start.
//  Spurious inputs:
//  - done_score_calc / done_score_board outside their WAIT states are ignored.
//  Abort:
//  - Next cycle: both FSMs IDLE, busy=0, pulses 0, counters 0, no done_registration.
//  - abort wins over a simultaneous start or done.
//  Wrap:
//  - Set counters never exceed num_of_sets-1.
//  - num_of_sets = 2^SET_LEN-1 is the maximum legal set count.
// TESTING
//  1. First frame, sets=3, num_of_pe=5, board latency 4 -> no start_score_calc; row_sel 0,1,2;
//     ids 6,30,54; a single done pulse.
//  2. frame_num=7, sets=3, calc latency 2, board latency 6 -> calc set1 overlaps board set0;
//     HOLD observed; board order 0,1,2; one done pulse.
//  3. done_score_calc and done_score_board in the same cycle -> start_score_board the next cycle
//     with no idle gap.
//  4. num_of_sets=0 -> err_empty 1-cycle pulse; busy, start_score_calc and start_score_board
//     stay 0.
//  5. abort during board of set1 -> idle next cycle, no done.
//     Start while busy is ignored; a fresh start afterward runs normally.
//  6. reset_N low mid-WAIT, asynchronously -> all outputs 0 before the next clk edge;
//     a clean restart after release.

Source files
------------

// File: rtl/oflow_registration_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// oflow_registration_ctrl_pipe
//
// Pipelined registration controller. Walks num_of_sets PE sets through the
// score-calc stage and then the score-board stage. Calc of set k+1 runs while
// set k is on the board. On the first frame (frame_num == 0) score calc is
// skipped and the board stage walks the sets directly, issuing a new ID for
// each PE.
//
// Ports
//   clk, reset_N          clock, async active-low reset
//   start_registration    1-cycle start request (ignored while busy)
//   abort                 synchronous abort, beats start and done
//   frame_num             current frame, 0 = first frame
//   num_of_sets           sets to process this frame
//   num_of_pe             PE index inside the set (ID generation)
//   done_score_calc       calc engine finished calc_set
//   start_score_calc      1-cycle pulse, calc_set valid
//   calc_set              set index in the calc stage
//   done_score_board      board engine finished row_sel_by_set
//   start_score_board     1-cycle pulse, row_sel_by_set valid
//   row_sel_by_set        set index in the board stage
//   id_first_frame        new ID on the first frame, 0 otherwise
//   busy                  registration in progress
//   done_registration     1-cycle pulse, all sets registered
//   err_empty             1-cycle pulse, start with num_of_sets == 0
// ----------------------------------------------------------------------------
module oflow_registration_ctrl_pipe #(
    parameter int PE_NUM  = 24,
    parameter int PE_LEN  = 5,
    parameter int SET_LEN = 3,
    parameter int ID_LEN  = 12,
    parameter int FRAME_W = 16
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start_registration,
    input  logic               abort,
    input  logic [FRAME_W-1:0] frame_num,
    input  logic [SET_LEN-1:0] num_of_sets,
    input  logic [PE_LEN-1:0]  num_of_pe,
    input  logic               done_score_calc,
    output logic               start_score_calc,
    output logic [SET_LEN-1:0] calc_set,
    input  logic               done_score_board,
    output logic               start_score_board,
    output logic [SET_LEN-1:0] row_sel_by_set,
    output logic [ID_LEN-1:0]  id_first_frame,
    output logic               busy,
    output logic               done_registration,
    output logic               err_empty
);

    typedef enum logic [1:0] {C_IDLE, C_START, C_WAIT, C_HOLD} calc_st_t;
    typedef enum logic [1:0] {B_IDLE, B_START, B_WAIT} board_st_t;

    calc_st_t           calc_st;
    board_st_t          board_st;
    logic               first_frame;
    logic [SET_LEN-1:0] sets_lat;
    logic [SET_LEN-1:0] last_set;
    logic               board_free;
    logic               calc_ready;
    logic               handoff;

    assign last_set = sets_lat - SET_LEN'(1);

    // Board counts as free if it is idle or finishing in this very cycle,
    // which lets the next set start on the board without a bubble.
    assign board_free = (board_st == B_IDLE) || ((board_st == B_WAIT) && done_score_board);
    assign calc_ready = ((calc_st == C_WAIT) && done_score_calc) || (calc_st == C_HOLD);
    assign handoff    = busy && calc_ready && board_free;

    assign id_first_frame = first_frame
                          ? ID_LEN'(row_sel_by_set) * ID_LEN'(PE_NUM) + ID_LEN'(num_of_pe) + ID_LEN'(1)
                          : '0;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            calc_st           <= C_IDLE;
            board_st          <= B_IDLE;
            first_frame       <= 1'b0;
            sets_lat          <= '0;
            calc_set          <= '0;
            row_sel_by_set    <= '0;
            start_score_calc  <= 1'b0;
            start_score_board <= 1'b0;
            busy              <= 1'b0;
            done_registration <= 1'b0;
            err_empty         <= 1'b0;
        end else begin
            start_score_calc  <= 1'b0;
            start_score_board <= 1'b0;
            done_registration <= 1'b0;
            err_empty         <= 1'b0;

            if (abort) begin
                calc_st        <= C_IDLE;
                board_st       <= B_IDLE;
                busy           <= 1'b0;
                first_frame    <= 1'b0;
                calc_set       <= '0;
                row_sel_by_set <= '0;
            end else if (!busy) begin
                if (start_registration) begin
                    if (num_of_sets == '0) begin
                        err_empty <= 1'b1;
                    end else begin
                        busy           <= 1'b1;
                        sets_lat       <= num_of_sets;
                        first_frame    <= (frame_num == '0);
                        calc_set       <= '0;
                        row_sel_by_set <= '0;
                        if (frame_num == '0) begin
                            board_st          <= B_START;
                            start_score_board <= 1'b1;
                        end else begin
                            calc_st          <= C_START;
                            start_score_calc <= 1'b1;
                        end
                    end
                end
            end else begin
                case (board_st)
                    B_START: board_st <= B_WAIT;
                    B_WAIT: begin
                        if (done_score_board) begin
                            if (row_sel_by_set == last_set) begin
                                done_registration <= 1'b1;
                                busy              <= 1'b0;
                                board_st          <= B_IDLE;
                            end else if (first_frame) begin
                                row_sel_by_set    <= row_sel_by_set + SET_LEN'(1);
                                board_st          <= B_START;
                                start_score_board <= 1'b1;
                            end else begin
                                board_st <= B_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase

                case (calc_st)
                    C_START: calc_st <= C_WAIT;
                    C_WAIT:  if (done_score_calc && !board_free) calc_st <= C_HOLD;
                    default: ;
                endcase

                // Handoff overrides the board decisions above: a board that
                // just finished is restarted on the set leaving calc.
                if (handoff) begin
                    row_sel_by_set    <= calc_set;
                    board_st          <= B_START;
                    start_score_board <= 1'b1;
                    if (calc_set != last_set) begin
                        calc_set         <= calc_set + SET_LEN'(1);
                        calc_st          <= C_START;
                        start_score_calc <= 1'b1;
                    end else begin
                        calc_st <= C_IDLE;
                    end
                end
            end
        end
    end

endmodule
